// File: rtl/ethernet_tx_arbiter_pkg.sv
// ethernet_tx_arbiter_pkg
//   Shared types for the Ethernet TX arbiter.
//   state_e : arbiter FSM states (IDLE, DATA, SIZE, SEND, DRAIN).
package ethernet_tx_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DATA  = 3'd1,
    SIZE  = 3'd2,
    SEND  = 3'd3,
    DRAIN = 3'd4
  } state_e;

endpackage

// File: rtl/bsg_arb_round_robin.sv
// bsg_arb_round_robin
//   Round-robin selector. Reports the highest-priority requester; when the
//   choice is consumed (yumi_i with v_o) priority rotates past the winner.
// Ports:
//   clk_i, reset_i : clock, async active-high reset (priority to req 0)
//   reqs_i         : request vector
//   yumi_i         : the current choice is taken this cycle
//   v_o            : some request is present
//   grant_id_o     : index of the chosen requester
module bsg_arb_round_robin #(
  parameter  int unsigned width_p = 2,
  localparam int unsigned id_w    = $clog2(width_p)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] reqs_i,
  input  logic               yumi_i,
  output logic               v_o,
  output logic [id_w-1:0]    grant_id_o
);

  logic [id_w-1:0]    r_last;
  logic [width_p-1:0] w_rot;
  int unsigned        w_sum;

  // Rotate so bit 0 is the requester just after the last winner, then take
  // the lowest set bit and map it back to an absolute index.
  always_comb begin
    v_o        = 1'b0;
    grant_id_o = '0;
    w_sum      = 0;
    w_rot      = width_p'({reqs_i, reqs_i} >> (32'(r_last) + 32'd1));
    for (int unsigned k = 0; k < width_p; k++) begin
      if (!v_o && w_rot[k]) begin
        v_o   = 1'b1;
        w_sum = 32'(r_last) + 32'd1 + k;
        if (w_sum >= width_p) w_sum = w_sum - width_p;
        grant_id_o = id_w'(w_sum);
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) r_last <= id_w'(width_p - 1);
    else if (yumi_i && v_o) r_last <= grant_id_o;
  end

endmodule

// File: rtl/ethernet_tx_arbiter.sv
// ethernet_tx_arbiter
//   Shares the ethernet_sender host write port between num_req_p packet
//   streams. One requester owns the port for a whole packet; its beats become
//   buffer writes, then a size write, then a send pulse. Packets longer than
//   eth_mtu_p are dropped and the rest of the packet drained.
// Ports:
//   clk_i, reset_i                 : clock, async active-high reset
//   req_v_i/req_data_i/req_last_i  : per-requester beat stream
//   req_last_bytes_i               : valid bytes in last beat, 0 = full word
//   req_ready_o                    : per-requester accept
//   packet_req_i                   : sender has buffer space
//   packet_wsize_valid_o/_wsize_o  : packet length write
//   packet_wvalid_o/_waddr_o/_wdata_o/_wdata_size_o : buffer word write
//   packet_send_o                  : commit pulse
//   grant_id_o, busy_o, drop_o     : status
module ethernet_tx_arbiter
  import ethernet_tx_arbiter_pkg::*;
#(
  parameter  int unsigned num_req_p    = 2,
  parameter  int unsigned data_width_p = 32,
  parameter  int unsigned eth_mtu_p    = 2048,
  localparam int unsigned bytes_lp     = data_width_p / 8,
  localparam int unsigned lb_w         = $clog2(bytes_lp),
  localparam int unsigned id_w         = $clog2(num_req_p),
  localparam int unsigned size_w       = $clog2(eth_mtu_p + 1),
  localparam int unsigned addr_w       = $clog2(eth_mtu_p),
  localparam int unsigned ws_w         = $clog2(lb_w + 1)
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [num_req_p-1:0]             req_v_i,
  input  logic [num_req_p*data_width_p-1:0] req_data_i,
  input  logic [num_req_p-1:0]             req_last_i,
  input  logic [num_req_p*lb_w-1:0]        req_last_bytes_i,
  output logic [num_req_p-1:0]             req_ready_o,
  input  logic                             packet_req_i,
  output logic                             packet_wsize_valid_o,
  output logic [size_w-1:0]                packet_wsize_o,
  output logic                             packet_wvalid_o,
  output logic [addr_w-1:0]                packet_waddr_o,
  output logic [data_width_p-1:0]          packet_wdata_o,
  output logic [ws_w-1:0]                  packet_wdata_size_o,
  output logic                             packet_send_o,
  output logic [id_w-1:0]                  grant_id_o,
  output logic                             busy_o,
  output logic                             drop_o
);

  localparam int unsigned max_beats_lp = eth_mtu_p / bytes_lp;
  localparam int unsigned beat_w       = $clog2(max_beats_lp + 1);
  localparam logic [beat_w-1:0] MaxBeats = beat_w'(max_beats_lp);

  state_e                  r_state, w_next;
  logic [id_w-1:0]         r_grant;
  logic [beat_w-1:0]       r_beat_cnt;
  logic [size_w-1:0]       r_byte_cnt;

  logic                    w_rr_v, w_start, w_accept, w_room;
  logic [id_w-1:0]         w_rr_id;
  logic                    w_v, w_last;
  logic [data_width_p-1:0] w_data;
  logic [lb_w-1:0]         w_lb;
  logic [size_w-1:0]       w_inc;
  logic [num_req_p-1:0]    w_onehot;

  bsg_arb_round_robin #(.width_p(num_req_p)) u_rr (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .reqs_i     (req_v_i),
    .yumi_i     (w_start),
    .v_o        (w_rr_v),
    .grant_id_o (w_rr_id)
  );

  // Granted requester's beat
  always_comb begin
    w_v    = 1'b0;
    w_last = 1'b0;
    w_data = '0;
    w_lb   = '0;
    for (int unsigned i = 0; i < num_req_p; i++) begin
      if (r_grant == id_w'(i)) begin
        w_v    = req_v_i[i];
        w_last = req_last_i[i];
        w_data = req_data_i[i*data_width_p +: data_width_p];
        w_lb   = req_last_bytes_i[i*lb_w +: lb_w];
      end
    end
  end

  assign w_start  = (r_state == IDLE) && packet_req_i && w_rr_v;
  assign w_room   = (r_beat_cnt < MaxBeats);
  assign w_accept = w_v && (((r_state == DATA) && packet_req_i) || (r_state == DRAIN));
  assign w_inc    = (w_last && (w_lb != '0)) ? size_w'(w_lb) : size_w'(bytes_lp);
  assign w_onehot = {{(num_req_p-1){1'b0}}, 1'b1} << r_grant;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (w_start) w_next = DATA;
      DATA: begin
        if (w_accept && w_last) w_next = w_room ? SIZE : IDLE;
        else if (w_accept && !w_room) w_next = DRAIN;
      end
      SIZE:  if (packet_req_i) w_next = SEND;
      SEND:  if (packet_req_i) w_next = IDLE;
      DRAIN: if (w_accept && w_last) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready_o          = '0;
    packet_wsize_valid_o = 1'b0;
    packet_wvalid_o      = 1'b0;
    packet_send_o        = 1'b0;
    drop_o               = 1'b0;
    case (r_state)
      DATA: begin
        req_ready_o     = packet_req_i ? w_onehot : '0;
        packet_wvalid_o = w_accept && w_room;
        drop_o          = w_accept && !w_room;
      end
      DRAIN: req_ready_o = w_onehot;
      SIZE:  packet_wsize_valid_o = packet_req_i;
      SEND:  packet_send_o = packet_req_i;
      default: ;
    endcase
  end

  assign packet_wsize_o      = r_byte_cnt;
  assign packet_waddr_o      = addr_w'({r_beat_cnt, {lb_w{1'b0}}});
  assign packet_wdata_o      = w_data;
  assign packet_wdata_size_o = ws_w'(lb_w);
  assign grant_id_o          = r_grant;
  assign busy_o              = (r_state != IDLE);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_grant    <= '0;
      r_beat_cnt <= '0;
      r_byte_cnt <= '0;
    end else if (w_start) begin
      r_grant    <= w_rr_id;
      r_beat_cnt <= '0;
      r_byte_cnt <= '0;
    end else if ((r_state == DATA) && w_accept && w_room) begin
      r_beat_cnt <= r_beat_cnt + beat_w'(1);
      r_byte_cnt <= r_byte_cnt + w_inc;
    end
  end

endmodule

// File: tb/tb_ethernet_tx_arbiter.sv
module tb_ethernet_tx_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 32-bit data, MTU 2048
  logic        a_rst, a_preq;
  logic [1:0]  a_v, a_last, a_ready;
  logic [63:0] a_data;
  logic [3:0]  a_lb;
  logic        a_wsv, a_wv, a_send, a_busy, a_drop;
  logic [11:0] a_wsize;
  logic [10:0] a_waddr;
  logic [31:0] a_wdata;
  logic [1:0]  a_wds;
  logic [0:0]  a_gid;

  // 64-bit data, MTU 64
  logic         b_rst, b_preq;
  logic [1:0]   b_v, b_last, b_ready;
  logic [127:0] b_data;
  logic [5:0]   b_lb;
  logic         b_wsv, b_wv, b_send, b_busy, b_drop;
  logic [6:0]   b_wsize;
  logic [5:0]   b_waddr;
  logic [63:0]  b_wdata;
  logic [1:0]   b_wds;
  logic [0:0]   b_gid;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  ethernet_tx_arbiter #(.num_req_p(2), .data_width_p(32), .eth_mtu_p(2048)) u_a (
    .clk_i(clk), .reset_i(a_rst), .req_v_i(a_v), .req_data_i(a_data),
    .req_last_i(a_last), .req_last_bytes_i(a_lb), .req_ready_o(a_ready),
    .packet_req_i(a_preq), .packet_wsize_valid_o(a_wsv), .packet_wsize_o(a_wsize),
    .packet_wvalid_o(a_wv), .packet_waddr_o(a_waddr), .packet_wdata_o(a_wdata),
    .packet_wdata_size_o(a_wds), .packet_send_o(a_send), .grant_id_o(a_gid),
    .busy_o(a_busy), .drop_o(a_drop)
  );

  ethernet_tx_arbiter #(.num_req_p(2), .data_width_p(64), .eth_mtu_p(64)) u_b (
    .clk_i(clk), .reset_i(b_rst), .req_v_i(b_v), .req_data_i(b_data),
    .req_last_i(b_last), .req_last_bytes_i(b_lb), .req_ready_o(b_ready),
    .packet_req_i(b_preq), .packet_wsize_valid_o(b_wsv), .packet_wsize_o(b_wsize),
    .packet_wvalid_o(b_wv), .packet_waddr_o(b_waddr), .packet_wdata_o(b_wdata),
    .packet_wdata_size_o(b_wds), .packet_send_o(b_send), .grant_id_o(b_gid),
    .busy_o(b_busy), .drop_o(b_drop)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_a(input int r, input logic v, input logic [31:0] d,
                       input logic last, input logic [1:0] lb);
    a_v[r]            = v;
    a_data[r*32 +: 32] = d;
    a_last[r]         = last;
    a_lb[r*2 +: 2]    = lb;
  endtask

  task automatic set_b(input int r, input logic v, input logic [63:0] d,
                       input logic last, input logic [2:0] lb);
    b_v[r]            = v;
    b_data[r*64 +: 64] = d;
    b_last[r]         = last;
    b_lb[r*3 +: 3]    = lb;
  endtask

  initial begin
    a_rst = 1'b1; a_preq = 1'b0; a_v = '0; a_data = '0; a_last = '0; a_lb = '0;
    b_rst = 1'b1; b_preq = 1'b0; b_v = '0; b_data = '0; b_last = '0; b_lb = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy",  64'(a_busy),  64'd0);
    chk("rst_ready", 64'(a_ready), 64'd0);
    chk("rst_gid",   64'(a_gid),   64'd0);
    chk("rst_wv",    64'(a_wv),    64'd0);
    chk("rst_drop",  64'(b_drop),  64'd0);
    chk("wds32",     64'(a_wds),   64'd2);
    chk("wds64",     64'(b_wds),   64'd3);
    a_rst = 1'b0; b_rst = 1'b0;

    // T1: 3-beat packet from req0, last beat 2 bytes
    @(negedge clk); a_preq = 1'b1; set_a(0, 1'b1, 32'h1111_1111, 1'b0, 2'd0); #1;
    chk("t1_idle_ready", 64'(a_ready), 64'd0);
    @(negedge clk); #1;
    chk("t1_b0_ready", 64'(a_ready), 64'd1);
    chk("t1_b0_wv",    64'(a_wv),    64'd1);
    chk("t1_b0_waddr", 64'(a_waddr), 64'd0);
    chk("t1_b0_wdata", 64'(a_wdata), 64'h1111_1111);
    chk("t1_busy",     64'(a_busy),  64'd1);
    @(negedge clk); set_a(0, 1'b1, 32'h2222_2222, 1'b0, 2'd0); #1;
    chk("t1_b1_waddr", 64'(a_waddr), 64'd4);
    @(negedge clk); set_a(0, 1'b1, 32'h3333_3333, 1'b1, 2'd2); #1;
    chk("t1_b2_waddr", 64'(a_waddr), 64'd8);
    chk("t1_b2_wv",    64'(a_wv),    64'd1);
    chk("t1_b2_drop",  64'(a_drop),  64'd0);
    @(negedge clk); set_a(0, 1'b0, 32'h0, 1'b0, 2'd0); #1;
    chk("t1_wsv",   64'(a_wsv),   64'd1);
    chk("t1_wsize", 64'(a_wsize), 64'd10);
    chk("t1_sz_wv", 64'(a_wv),    64'd0);
    @(negedge clk); #1;
    chk("t1_send", 64'(a_send), 64'd1);
    chk("t1_sd_wsv", 64'(a_wsv), 64'd0);
    @(negedge clk); #1;
    chk("t1_send_off", 64'(a_send), 64'd0);
    chk("t1_idle",     64'(a_busy), 64'd0);

    // T2: both requesters valid, four single-beat packets
    @(negedge clk); a_rst = 1'b1; #2; a_rst = 1'b0;
    set_a(0, 1'b1, 32'hA0A0_A0A0, 1'b1, 2'd0);
    set_a(1, 1'b1, 32'hB1B1_B1B1, 1'b1, 2'd0);
    for (int p = 0; p < 4; p++) begin
      #1;
      chk("t2_idle", 64'(a_busy), 64'd0);
      @(negedge clk); #1;
      chk("t2_gid",   64'(a_gid),   64'(p % 2));
      chk("t2_ready", 64'(a_ready), 64'((p % 2) == 0 ? 1 : 2));
      chk("t2_wv",    64'(a_wv),    64'd1);
      chk("t2_wdata", 64'(a_wdata), (p % 2) == 0 ? 64'hA0A0_A0A0 : 64'hB1B1_B1B1);
      @(negedge clk); #1;
      chk("t2_wsv",   64'(a_wsv),   64'd1);
      chk("t2_wsize", 64'(a_wsize), 64'd4);
      @(negedge clk); #1;
      chk("t2_send",  64'(a_send),  64'd1);
      @(negedge clk);
    end
    a_v = '0; #1;
    chk("t2_end_idle", 64'(a_busy), 64'd0);

    // T3: packet_req_i dropping in DATA, SIZE, SEND
    @(negedge clk); set_a(0, 1'b1, 32'hE0E0_0000, 1'b0, 2'd0); a_preq = 1'b1; #1;
    chk("t3_idle", 64'(a_busy), 64'd0);
    @(negedge clk); a_preq = 1'b0; #1;
    chk("t3_hold_ready", 64'(a_ready), 64'd0);
    chk("t3_hold_wv",    64'(a_wv),    64'd0);
    chk("t3_hold_busy",  64'(a_busy),  64'd1);
    @(negedge clk); a_preq = 1'b1; #1;
    chk("t3_b0_ready", 64'(a_ready), 64'd1);
    chk("t3_b0_waddr", 64'(a_waddr), 64'd0);
    chk("t3_b0_wdata", 64'(a_wdata), 64'hE0E0_0000);
    @(negedge clk); set_a(0, 1'b1, 32'hE0E0_0001, 1'b1, 2'd3); #1;
    chk("t3_b1_waddr", 64'(a_waddr), 64'd4);
    chk("t3_b1_wv",    64'(a_wv),    64'd1);
    @(negedge clk); set_a(0, 1'b0, 32'h0, 1'b0, 2'd0); a_preq = 1'b0; #1;
    chk("t3_hold_wsv", 64'(a_wsv), 64'd0);
    @(negedge clk); a_preq = 1'b1; #1;
    chk("t3_wsv",   64'(a_wsv),   64'd1);
    chk("t3_wsize", 64'(a_wsize), 64'd7);
    @(negedge clk); a_preq = 1'b0; #1;
    chk("t3_hold_send", 64'(a_send), 64'd0);
    @(negedge clk); a_preq = 1'b1; #1;
    chk("t3_send", 64'(a_send), 64'd1);
    @(negedge clk); #1;
    chk("t3_end_idle", 64'(a_busy), 64'd0);

    // T6: reset in the middle of a packet
    @(negedge clk); set_a(0, 1'b1, 32'hC0C0_0000, 1'b0, 2'd0); #1;
    @(negedge clk); #1;
    chk("t6_b0_waddr", 64'(a_waddr), 64'd0);
    @(negedge clk); set_a(0, 1'b1, 32'hC0C0_0001, 1'b0, 2'd0); #1;
    chk("t6_b1_waddr", 64'(a_waddr), 64'd4);
    a_rst = 1'b1; #1;
    chk("t6_rst_wv",    64'(a_wv),    64'd0);
    chk("t6_rst_ready", 64'(a_ready), 64'd0);
    chk("t6_rst_busy",  64'(a_busy),  64'd0);
    @(negedge clk); a_rst = 1'b0;
    set_a(0, 1'b1, 32'hD0D0_D0D0, 1'b1, 2'd0);
    set_a(1, 1'b1, 32'hD1D1_D1D1, 1'b1, 2'd0);
    @(negedge clk); #1;
    chk("t6_gid",   64'(a_gid),   64'd0);
    chk("t6_waddr", 64'(a_waddr), 64'd0);
    chk("t6_wdata", 64'(a_wdata), 64'hD0D0_D0D0);
    @(negedge clk); a_v = '0; #1;
    chk("t6_wsize", 64'(a_wsize), 64'd4);
    @(negedge clk); #1;
    chk("t6_send", 64'(a_send), 64'd1);

    // T4: 64-bit, MTU 64, 9-beat packet overflows
    @(negedge clk); b_preq = 1'b1; set_b(0, 1'b1, 64'hF000_0000_0000_0000, 1'b0, 3'd0); #1;
    chk("t4_idle", 64'(b_busy), 64'd0);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      set_b(0, 1'b1, 64'hF000_0000_0000_0000 + 64'(i), (i == 8), 3'd0); #1;
      if (i < 8) begin
        chk("t4_wv",    64'(b_wv),    64'd1);
        chk("t4_waddr", 64'(b_waddr), 64'(8 * i));
        chk("t4_wdata", 64'(b_wdata), 64'hF000_0000_0000_0000 + 64'(i));
        chk("t4_drop",  64'(b_drop),  64'd0);
      end else begin
        chk("t4_ovf_wv",   64'(b_wv),   64'd0);
        chk("t4_ovf_drop", 64'(b_drop), 64'd1);
      end
    end
    @(negedge clk); set_b(0, 1'b0, 64'h0, 1'b0, 3'd0); #1;
    chk("t4_end_idle", 64'(b_busy), 64'd0);
    chk("t4_no_wsv",   64'(b_wsv),  64'd0);
    chk("t4_no_send",  64'(b_send), 64'd0);
    chk("t4_drop_off", 64'(b_drop), 64'd0);

    // T5: 64-bit, exactly MTU bytes, full last word
    @(negedge clk); set_b(0, 1'b1, 64'h5500_0000_0000_0000, 1'b0, 3'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      set_b(0, 1'b1, 64'h5500_0000_0000_0000 + 64'(i), (i == 7), 3'd0); #1;
      chk("t5_wv",    64'(b_wv),    64'd1);
      chk("t5_waddr", 64'(b_waddr), 64'(8 * i));
      chk("t5_drop",  64'(b_drop),  64'd0);
    end
    @(negedge clk); set_b(0, 1'b0, 64'h0, 1'b0, 3'd0); #1;
    chk("t5_wsv",   64'(b_wsv),   64'd1);
    chk("t5_wsize", 64'(b_wsize), 64'd64);
    @(negedge clk); #1;
    chk("t5_send", 64'(b_send), 64'd1);
    @(negedge clk); #1;
    chk("t5_end_idle", 64'(b_busy), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
